uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning the tx_clk cycles per serial bit; minimum 2.
REQ-003 The block SHALL have parameter PARITY, default 0, meaning the parity mode: 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning the stop bits per frame: 1 or 2.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the transmit FIFO entries; power of 2, minimum 2.

Ports (name, direction, width, meaning):
REQ-006 tx_clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 tx_data  in  DATA_BITS  word to enqueue.
REQ-009 tx_start  in  1  enqueue request, edge-detected.
REQ-010 tx_complete_del_flag  in  1  clears tx_complete_flag.
REQ-011 TXD  out  1  serial line, idle high.
REQ-012 tx_complete_flag  out  1  frame-finished flag.
REQ-013 tx_busy  out  1  FIFO non-empty or frame in progress.
REQ-014 tx_full  out  1  FIFO holds FIFO_DEPTH words.
REQ-015 tx_overflow  out  1  sticky: a push was dropped.

Function
REQ-016 Push: the block SHALL enqueue tx_data at edge E only when tx_start=1 at E and tx_start=0 at E-1; holding tx_start high SHALL enqueue exactly one word.
REQ-017 A push while tx_full=1 SHALL be dropped and SHALL set tx_overflow; FIFO contents SHALL be unchanged.
REQ-018 A push and a pop at the same edge while full SHALL both succeed and SHALL NOT set tx_overflow.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; tx_full and the empty state SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-020 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-021 IDLE: TXD=1; when the FIFO is non-empty the FSM SHALL pop the head word into a shift register and enter START at the same edge.
REQ-022 START: TXD=0 for CLKS_PER_BIT cycles, then the FSM SHALL enter DATA.
REQ-023 DATA: the block SHALL send DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles; then the FSM SHALL enter PARITY if PARITY!=0, else STOP.
REQ-024 PARITY: TXD SHALL be the XOR of the data bits for even parity and its inverse for odd parity, for CLKS_PER_BIT cycles.
REQ-025 STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-026 At the last STOP cycle, if the FIFO is non-empty the FSM SHALL pop and go directly to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-027 Latency: a push at edge E into an empty FIFO with the FSM in IDLE SHALL drive TXD low from edge E+1.
REQ-028 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
REQ-029 tx_complete_flag SHALL set at the edge ending each frame's last stop bit and hold until an edge with tx_complete_del_flag=1.
REQ-030 If a set and a clear of tx_complete_flag coincide, the set SHALL win.
REQ-031 tx_busy SHALL be 1 whenever the FSM is not in IDLE or the FIFO is non-empty.
REQ-032 tx_data SHALL be sampled only at the push edge; later changes SHALL NOT affect queued frames.

Reset
REQ-033 While reset=1, independent of tx_clk: TXD=1, tx_complete_flag=0, tx_busy=0, tx_full=0, tx_overflow=0, FIFO empty, FSM in IDLE, counters 0, and the tx_start edge history register 0.
REQ-034 Reset mid-frame SHALL abort the frame immediately with TXD=1; no completion flag SHALL be raised for the aborted frame.
REQ-035 After reset deasserts, tx_start already high SHALL count as a rising edge at the first clock.

Verification
REQ-036 Defaults; push 8'h2F with tx_start held high 5 cycles -> one frame 0,1,1,1,1,0,1,0,0,1 (160 cycles); tx_complete_flag sets at end; tx_busy falls at the same edge.
REQ-037 PARITY=1 then PARITY=2, data 8'h2F -> parity bit 1 then 0; frame 176 cycles.
REQ-038 Six pushes (A0..A5) 2 cycles apart while idle -> A0 sent immediately; A1..A4 queued, tx_full=1; A5 dropped, tx_overflow=1; five back-to-back frames with no idle cycles.
REQ-039 STOP_BITS=2, DATA_BITS=7, data 7'h55 -> TXD high for 32 cycles after bit 6; frame 160 cycles.
REQ-040 tx_complete_del_flag asserted on the same edge the next frame ends -> tx_complete_flag stays 1.
REQ-041 Reset asserted mid-DATA with 2 words queued -> TXD=1 and all flags 0 immediately; no further frames after release.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: edge-detected pushes, back-to-back
// framing with optional parity and one or two stop bits, sticky overflow.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 tx_clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  input  logic                 tx_complete_del_flag,
  output logic                 TXD,
  output logic                 tx_complete_flag,
  output logic                 tx_busy,
  output logic                 tx_full,
  output logic                 tx_overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam bit HAS_PARITY = (PARITY != 0);
  localparam bit ODD_PARITY = (PARITY == 2);
  localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] CNT_ZERO   = {NW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    parity_of = ODD_PARITY ? ~(^word) : (^word);
  endfunction

  state_t                state_r;
  logic [CW-1:0]         clk_cnt_r;
  logic [BW-1:0]         bit_cnt_r;
  logic [DATA_BITS-1:0]  shift_r;
  logic                  parity_r;
  logic                  txd_r;
  logic                  busy_r;
  logic                  full_r;
  logic                  ovf_r;
  logic                  cflag_r;
  logic                  start_d_r;
  logic [DATA_BITS-1:0]  mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [NW-1:0]         count_r;

  logic                  start_edge_s;
  logic                  bit_end_s;
  logic                  stop_last_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [NW-1:0]         count_nxt_s;
  logic [DATA_BITS-1:0]  head_s;

  assign TXD              = txd_r;
  assign tx_complete_flag = cflag_r;
  assign tx_busy          = busy_r;
  assign tx_full          = full_r;
  assign tx_overflow      = ovf_r;

  // Push/pop arbitration; a pop frees a slot so a push into a full FIFO still lands.
  always_comb begin
    start_edge_s = tx_start & ~start_d_r;
    bit_end_s    = (clk_cnt_r == CLK_LAST);
    stop_last_s  = (state_r == ST_STOP) && bit_end_s && (bit_cnt_r == STOP_LAST);
    pop_s        = (count_r != CNT_ZERO) && ((state_r == ST_IDLE) || stop_last_s);
    push_s       = start_edge_s && ((count_r != FULL_COUNT) || pop_s);
    drop_s       = start_edge_s && !push_s;
    head_s       = mem_r[rd_ptr_r];
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + NW'(1'b1);
      2'b01:   count_nxt_s = count_r - NW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents are only read after being written.
  always_ff @(posedge tx_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers, occupancy, start edge history and sticky overflow.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      start_d_r <= 1'b0;
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= CNT_ZERO;
      full_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      start_d_r <= tx_start;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_COUNT);
      if (drop_s) ovf_r <= 1'b1;
    end
  end

  // Frame sequencer; TXD and tx_busy are registered to reflect the post-edge state.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      clk_cnt_r <= {CW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      parity_r  <= 1'b0;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          txd_r <= 1'b1;
          if (pop_s) begin
            state_r   <= ST_START;
            txd_r     <= 1'b0;
            shift_r   <= head_s;
            parity_r  <= parity_of(head_s);
            clk_cnt_r <= {CW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
          end else begin
            busy_r <= (count_nxt_s != CNT_ZERO);
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r   <= ST_DATA;
            clk_cnt_r <= {CW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            txd_r     <= shift_r[0];
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1'b1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            clk_cnt_r <= {CW{1'b0}};
            if (bit_cnt_r == DATA_LAST) begin
              bit_cnt_r <= {BW{1'b0}};
              if (HAS_PARITY) begin
                state_r <= ST_PARITY;
                txd_r   <= parity_r;
              end else begin
                state_r <= ST_STOP;
                txd_r   <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BW'(1'b1);
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              txd_r     <= shift_r[1];
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1'b1);
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r   <= ST_STOP;
            clk_cnt_r <= {CW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            txd_r     <= 1'b1;
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1'b1);
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            clk_cnt_r <= {CW{1'b0}};
            if (bit_cnt_r == STOP_LAST) begin
              bit_cnt_r <= {BW{1'b0}};
              // Next queued word starts without an idle cycle.
              if (pop_s) begin
                state_r  <= ST_START;
                txd_r    <= 1'b0;
                shift_r  <= head_s;
                parity_r <= parity_of(head_s);
              end else begin
                state_r <= ST_IDLE;
                txd_r   <= 1'b1;
                busy_r  <= (count_nxt_s != CNT_ZERO);
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BW'(1'b1);
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          clk_cnt_r <= {CW{1'b0}};
          bit_cnt_r <= {BW{1'b0}};
          txd_r     <= 1'b1;
          busy_r    <= (count_nxt_s != CNT_ZERO);
        end
      endcase
    end
  end

  // Completion flag: a frame end takes priority over a same-edge clear.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      cflag_r <= 1'b0;
    end else if (stop_last_s) begin
      cflag_r <= 1'b1;
    end else if (tx_complete_del_flag) begin
      cflag_r <= 1'b0;
    end else begin
      cflag_r <= cflag_r;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three differently-parameterised transmitters share one stimulus stream; each is
// compared every cycle against a queue-of-frames model plus directed spot checks.
module tb_uart_tx_fifo;

  localparam int NB  [3] = '{8, 9, 7};
  localparam int CPB [3] = '{16, 4, 2};
  localparam int PAR [3] = '{0, 1, 2};
  localparam int SB  [3] = '{1, 1, 2};
  localparam int DEP [3] = '{4, 2, 8};

  logic       tx_clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic       del = 1'b0;
  logic [8:0] tx_data = 9'h000;
  logic [2:0] txd, cflag, busy, full, ovf;

  int n_err = 0;
  int n_checks = 0;

  uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .tx_clk(tx_clk), .reset(reset), .tx_data(tx_data[7:0]), .tx_start(tx_start),
    .tx_complete_del_flag(del), .TXD(txd[0]), .tx_complete_flag(cflag[0]),
    .tx_busy(busy[0]), .tx_full(full[0]), .tx_overflow(ovf[0]));
  uart_tx_fifo #(.DATA_BITS(9), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u1 (
    .tx_clk(tx_clk), .reset(reset), .tx_data(tx_data[8:0]), .tx_start(tx_start),
    .tx_complete_del_flag(del), .TXD(txd[1]), .tx_complete_flag(cflag[1]),
    .tx_busy(busy[1]), .tx_full(full[1]), .tx_overflow(ovf[1]));
  uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(2), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) u2 (
    .tx_clk(tx_clk), .reset(reset), .tx_data(tx_data[6:0]), .tx_start(tx_start),
    .tx_complete_del_flag(del), .TXD(txd[2]), .tx_complete_flag(cflag[2]),
    .tx_busy(busy[2]), .tx_full(full[2]), .tx_overflow(ovf[2]));

  initial forever #5 tx_clk = ~tx_clk;

  // Reference model: mq holds queued words, mw the line levels still to be shown.
  int mq [3][$];
  bit mw [3][$];
  bit m_flag [3] = '{1'b0, 1'b0, 1'b0};
  bit m_ovf  [3] = '{1'b0, 1'b0, 1'b0};
  bit m_prev = 1'b0;

  always @(posedge tx_clk or posedge reset) begin : model
    bit m_edge, ending, popping, was_full, p;
    int w;
    if (reset) begin
      m_prev = 1'b0;
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        mw[k].delete();
        m_flag[k] = 1'b0;
        m_ovf[k]  = 1'b0;
      end
    end else begin
      m_edge = tx_start && !m_prev;
      m_prev = tx_start;
      for (int k = 0; k < 3; k++) begin
        ending = (mw[k].size() == 1);
        if (mw[k].size() > 0) void'(mw[k].pop_front());
        popping  = (mw[k].size() == 0) && (mq[k].size() > 0);
        was_full = (mq[k].size() == DEP[k]);
        if (popping) begin
          w = mq[k].pop_front();
          for (int c = 0; c < CPB[k]; c++) mw[k].push_back(1'b0);
          for (int b = 0; b < NB[k]; b++)
            for (int c = 0; c < CPB[k]; c++) mw[k].push_back(w[b]);
          p = ($countones(w) % 2) == 1;
          if (PAR[k] == 2) p = ~p;
          if (PAR[k] != 0)
            for (int c = 0; c < CPB[k]; c++) mw[k].push_back(p);
          for (int c = 0; c < SB[k] * CPB[k]; c++) mw[k].push_back(1'b1);
        end
        if (m_edge) begin
          if (!was_full || popping) mq[k].push_back(int'(tx_data) & ((1 << NB[k]) - 1));
          else m_ovf[k] = 1'b1;
        end
        if (ending) m_flag[k] = 1'b1;
        else if (del) m_flag[k] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle, then all outputs of all instances against the model.
  task automatic tick();
    @(negedge tx_clk);
    for (int k = 0; k < 3; k++) begin
      check("TXD",  k, txd[k],   (mw[k].size() > 0) ? mw[k][0] : 1'b1);
      check("busy", k, busy[k],  (mw[k].size() > 0) || (mq[k].size() > 0));
      check("full", k, full[k],  mq[k].size() == DEP[k]);
      check("ovf",  k, ovf[k],   m_ovf[k]);
      check("cflag", k, cflag[k], m_flag[k]);
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (busy != 3'b000 && n < limit) begin
      tick();
      n++;
    end
    check_int(tag, int'(busy), 0);
  endtask

  initial begin
    int nbusy;
    logic [9:0] pat;
    int nlow;

    repeat (3) tick();
    check("rst_TXD", 0, txd[0], 1'b1);
    check("rst_busy", 0, busy[0], 1'b0);
    reset = 1'b0;
    tick();

    // Single word, start held high five cycles; line pattern and frame length.
    tx_data = 9'h02F;
    tx_start = 1'b1;
    nbusy = 0;
    pat = 10'h000;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (c == 0) tx_data = 9'($urandom);
      if (c == 4) tx_start = 1'b0;
      if (busy[0]) nbusy++;
      if (c >= 1 && (c - 1) % 16 == 8 && (c - 1) / 16 < 10) pat[(c - 1) / 16] = txd[0];
      if (c > 0 && busy == 3'b000) break;
    end
    check_int("frame_busy_len", nbusy, (1 + 8 + 0 + 1) * 16 + 1);
    check_int("frame_pattern", int'(pat), int'(10'b1001011110));
    check("done_flag", 0, cflag[0], 1'b1);

    // Clear held high across a frame end: set wins, clear applies one edge later.
    del = 1'b1;
    tx_data = 9'h0A5;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    drain("drain_b", 500);
    check("set_wins", 0, cflag[0], 1'b1);
    tick();
    check("clear_after", 0, cflag[0], 1'b0);
    del = 1'b0;

    // Six pushes two cycles apart: four queued, sixth dropped, frames back-to-back.
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      tx_data = 9'h0A0 + 9'(i);
      tx_start = 1'b1;
      tick();
      if (busy[0]) nbusy++;
      tx_start = 1'b0;
      tick();
      if (busy[0]) nbusy++;
    end
    check("burst_full", 0, full[0], 1'b1);
    check("burst_ovf", 0, ovf[0], 1'b1);
    for (int c = 0; c < 1000 && busy[0]; c++) begin
      tick();
      if (busy[0]) nbusy++;
    end
    check_int("burst_busy_len", nbusy, 5 * 160 + 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-DATA with two words queued: immediate abort and silence afterwards.
    for (int i = 0; i < 3; i++) begin
      tx_data = 9'h150 + 9'(i);
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      tick();
    end
    repeat (44) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_TXD", 0, txd[0], 1'b1);
    check("abort_busy", 0, busy[0], 1'b0);
    check("abort_full", 0, full[0], 1'b0);
    check("abort_cflag", 0, cflag[0], 1'b0);
    tick();
    reset = 1'b0;
    nlow = 0;
    repeat (300) begin
      tick();
      if (txd[0] == 1'b0 || busy[0]) nlow++;
    end
    check_int("abort_silence", nlow, 0);

    // Start already high when reset releases counts as an edge.
    reset = 1'b1;
    tick();
    tx_start = 1'b1;
    tx_data = 9'h1C3;
    reset = 1'b0;
    tick();
    check("start_after_reset", 0, busy[0], 1'b1);
    repeat (3) tick();
    tx_start = 1'b0;
    drain("drain_e", 400);

    // Random traffic, clears and one reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      tx_start = ($urandom_range(0, 29) == 0);
      tx_data = 9'($urandom);
      del = ($urandom_range(0, 7) == 0);
      reset = (c == 2000);
      tick();
    end
    reset = 1'b0;
    tx_start = 1'b0;
    del = 1'b0;
    drain("drain_rand", 2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
